mem_sram_bridge: RTL and testbench



---
 rtl/mem_sram_bridge.sv | 199 +++++++++++++++++++
 tb/tb_mem_sram_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_bridge.sv
// Memory-bus target adapter: turns CDC-side mem_req_t transactions into single-port SRAM cycles
// and returns read (and optionally write) responses through a credit-counted in-order buffer.

package mem_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_RSVD  = 2'd3
  } mem_type_e;

  typedef struct packed {
    mem_type_e                 req_type;
    logic [MEM_ADDR_W-1:0]     req_addr;
    logic [MEM_DATA_W-1:0]     req_data;
    logic [MEM_DATA_W/8-1:0]   req_mask;
  } mem_req_t;

  typedef struct packed {
    mem_type_e                 resp_type;
    logic [MEM_DATA_W-1:0]     resp_data;
  } mem_resp_t;
endpackage

module mem_sram_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int RESP_DP    = 3,
  parameter int WR_RESP_EN = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  mem_req_t            req,
  output logic                resp_valid,
  input  logic                resp_ready,
  output mem_resp_t           resp,
  output logic                sram_ce,
  output logic                sram_we,
  output logic [ADDR_W-3:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_be,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int PW = (RESP_DP > 1) ? $clog2(RESP_DP) : 1;
  localparam int CW = $clog2(RESP_DP + 1);
  localparam int OW = $clog2(RESP_DP + RD_LAT + 1);

  logic              accept_s;
  logic              is_rd_s;
  logic              is_wr_s;
  logic              tag_vld_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] push_data_s;
  logic [OW-1:0]     occ_s;
  logic              unused_bits_s;

  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_wr_q, pipe_wr_d;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0] fifo_data_q [0:RESP_DP-1];
  logic              fifo_wr_q   [0:RESP_DP-1];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RESP_DP - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  function automatic logic [OW-1:0] count_ones(input logic [RD_LAT-1:0] v);
    logic [OW-1:0] c;
    c = {OW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      c = c + OW'(v[i]);
    end
    return c;
  endfunction

  // Every in-flight tag and buffered entry holds a credit, so the buffer can never overflow.
  assign occ_s     = count_ones(pipe_vld_q) + OW'(fifo_cnt_q);
  assign req_ready = !rst && (occ_s < OW'(RESP_DP));
  assign accept_s  = req_valid && req_ready;

  assign unused_bits_s = ^req.req_addr[1:0];

  // Request type decode.
  always_comb begin
    is_rd_s = 1'b0;
    is_wr_s = 1'b0;
    case (req.req_type)
      MEM_READ:  is_rd_s = 1'b1;
      MEM_WRITE: is_wr_s = 1'b1;
      default: begin
        is_rd_s = 1'b0;
        is_wr_s = 1'b0;
      end
    endcase
  end

  // SRAM strobes in the accept cycle; unknown request types never touch the array.
  always_comb begin
    sram_ce = 1'b0;
    sram_we = 1'b0;
    if (accept_s) begin
      sram_ce = is_rd_s || is_wr_s;
      sram_we = is_wr_s;
    end else begin
      sram_ce = 1'b0;
      sram_we = 1'b0;
    end
  end

  assign sram_addr  = req.req_addr[ADDR_W-1:2];
  assign sram_wdata = req.req_data[DATA_W-1:0];
  assign sram_be    = req.req_mask[DATA_W/8-1:0];

  assign tag_vld_s = accept_s && (is_rd_s || (is_wr_s && (WR_RESP_EN != 32'sd0)));

  // Tag shift pipe that tracks the SRAM read latency.
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_wr_d     = pipe_wr_q;
    pipe_vld_d[0] = tag_vld_s;
    pipe_wr_d[0]  = is_wr_s;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_wr_d[i]  = pipe_wr_q[i-1];
    end
  end

  assign push_s      = pipe_vld_q[RD_LAT-1];
  assign push_data_s = pipe_wr_q[RD_LAT-1] ? {DATA_W{1'b0}} : sram_rdata;
  assign resp_valid  = (fifo_cnt_q != {CW{1'b0}});
  assign pop_s       = resp_valid && resp_ready;

  // Response buffer occupancy update.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1'b1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1'b1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Control state: tag pipe, buffer pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= {RD_LAT{1'b0}};
      pipe_wr_q  <= {RD_LAT{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      fifo_cnt_q <= {CW{1'b0}};
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_wr_q  <= pipe_wr_d;
      if (push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_s) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Buffer storage is deliberately not reset; a read landing during reset is dropped.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      fifo_data_q[wr_ptr_q] <= push_data_s;
      fifo_wr_q[wr_ptr_q]   <= pipe_wr_q[RD_LAT-1];
    end
  end

  // Head entry presented as the response.
  always_comb begin
    resp           = '{resp_type: MEM_READ, resp_data: {MEM_DATA_W{1'b0}}};
    resp.resp_data = MEM_DATA_W'(fifo_data_q[rd_ptr_q]);
    if (fifo_wr_q[rd_ptr_q]) begin
      resp.resp_type = MEM_WRITE;
    end else begin
      resp.resp_type = MEM_READ;
    end
  end

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Directed bench for mem_sram_bridge: one silent-write instance and one write-response instance
// share the request stream, each backed by a 1-cycle-latency SRAM model.

module tb_mem_sram_bridge;
  import mem_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int RD_LAT  = 1;
  localparam int RESP_DP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  mem_req_t    req;
  logic        resp_ready;

  logic        req_ready, resp_valid, sram_ce, sram_we;
  mem_resp_t   resp;
  logic [29:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_be;

  logic        req_ready_b, resp_valid_b, sram_ce_b, sram_we_b;
  mem_resp_t   resp_b;
  logic [29:0] sram_addr_b;
  logic [31:0] sram_wdata_b, sram_rdata_b;
  logic [3:0]  sram_be_b;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  int n_chk = 0;
  int n_err = 0;
  int acc;

  always #5 clk = ~clk;

  mem_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RESP_DP(RESP_DP),
                    .WR_RESP_EN(0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req(req),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_be(sram_be), .sram_rdata(sram_rdata));

  mem_sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RESP_DP(RESP_DP),
                    .WR_RESP_EN(1)) u_dut_wr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b), .req(req),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp(resp_b),
    .sram_ce(sram_ce_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b),
    .sram_be(sram_be_b), .sram_rdata(sram_rdata_b));

  // SRAM models: byte-masked write, registered read data one cycle after the enable.
  always @(posedge clk) begin
    if (sram_ce && !sram_we) sram_rdata <= mem_a[sram_addr[5:0]];
    if (sram_ce && sram_we)
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem_a[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
    if (sram_ce_b && !sram_we_b) sram_rdata_b <= mem_b[sram_addr_b[5:0]];
    if (sram_ce_b && sram_we_b)
      for (int b = 0; b < 4; b++)
        if (sram_be_b[b]) mem_b[sram_addr_b[5:0]][8*b +: 8] <= sram_wdata_b[8*b +: 8];
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge for sampling.
  task automatic drive(input logic r, input logic v, input mem_type_e t, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic rr);
    @(posedge clk);
    #1;
    rst           = r;
    req_valid     = v;
    req.req_type  = t;
    req.req_addr  = a;
    req.req_data  = d;
    req.req_mask  = m;
    resp_ready    = rr;
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, 1'b0, MEM_IDLE, 32'h0, 32'h0, 4'h0, rr);
  endtask

  // The buffer must never be pushed while already full.
  always @(negedge clk) begin
    if (!rst && u_dut.push_s && (u_dut.fifo_cnt_q == 2'(RESP_DP)))
      chk_val("no_push_full", 32'd1, 32'd0);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req        = '0;
    resp_ready = 1'b1;

    drive(1'b1, 1'b1, MEM_READ, 32'h40, 32'h0, 4'hF, 1'b1);
    chk_val("rst_req_ready", 32'(req_ready), 32'd0);
    chk_val("rst_sram_ce", 32'(sram_ce), 32'd0);
    drive(1'b1, 1'b1, MEM_WRITE, 32'h40, 32'h1, 4'hF, 1'b1);
    chk_val("rst_sram_we", 32'(sram_we), 32'd0);
    chk_val("rst_sram_ce_wr", 32'(sram_ce), 32'd0);
    idle(1'b1);
    chk_val("post_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_val("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, MEM_WRITE, 32'(i * 4), 32'h1111_0000 | 32'(i), 4'hF, 1'b1);
    drive(1'b0, 1'b1, MEM_WRITE, 32'h40, 32'hDEADBEEF, 4'hF, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Plain read latency
    drive(1'b0, 1'b1, MEM_READ, 32'h40, 32'h0, 4'h0, 1'b1);
    chk_val("t1_sram_ce", 32'(sram_ce), 32'd1);
    chk_val("t1_sram_we", 32'(sram_we), 32'd0);
    chk_val("t1_sram_addr", 32'(sram_addr), 32'h10);
    idle(1'b1);
    chk_val("t1_resp_early", 32'(resp_valid), 32'd0);
    idle(1'b1);
    chk_val("t1_resp_valid", 32'(resp_valid), 32'd1);
    chk_val("t1_resp_type", 32'(resp.resp_type), 32'(MEM_READ));
    chk_val("t1_resp_data", resp.resp_data, 32'hDEADBEEF);
    idle(1'b1);
    chk_val("t1_resp_done", 32'(resp_valid), 32'd0);

    // Partial-mask write, silent, then read-back
    drive(1'b0, 1'b1, MEM_WRITE, 32'h40, 32'h12345678, 4'b0011, 1'b1);
    chk_val("t2_sram_ce", 32'(sram_ce), 32'd1);
    chk_val("t2_sram_we", 32'(sram_we), 32'd1);
    chk_val("t2_sram_be", 32'(sram_be), 32'h3);
    chk_val("t2_sram_wdata", sram_wdata, 32'h12345678);
    idle(1'b1);
    chk_val("t2_silent_1", 32'(resp_valid), 32'd0);
    idle(1'b1);
    chk_val("t2_silent_2", 32'(resp_valid), 32'd0);
    drive(1'b0, 1'b1, MEM_READ, 32'h40, 32'h0, 4'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk_val("t2_rb_valid", 32'(resp_valid), 32'd1);
    chk_val("t2_rb_data", resp.resp_data, 32'hDEAD5678);
    idle(1'b1);

    // Back-to-back reads at full throughput
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, (k < 8), (k < 8) ? MEM_READ : MEM_IDLE, 32'(k * 4), 32'h0, 4'h0, 1'b1);
      if (k < 8) chk_val($sformatf("t3_req_ready_%0d", k), 32'(req_ready), 32'd1);
      if (k >= 2) begin
        chk_val($sformatf("t3_resp_valid_%0d", k - 2), 32'(resp_valid), 32'd1);
        chk_val($sformatf("t3_resp_data_%0d", k - 2), resp.resp_data, 32'h1111_0000 | 32'(k - 2));
      end
    end
    idle(1'b1);
    chk_val("t3_drained", 32'(resp_valid), 32'd0);

    // Backpressure: credits stop acceptance at the buffer depth
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, MEM_READ, 32'(acc * 4), 32'h0, 4'h0, 1'b0);
      if (req_ready) acc++;
    end
    chk_val("t4_accepted", 32'(acc), 32'd3);
    chk_val("t4_req_ready_held", 32'(req_ready), 32'd0);
    chk_val("t4_head_stable", resp.resp_data, 32'h1111_0000);
    idle(1'b1);
    chk_val("t4_pop0_valid", 32'(resp_valid), 32'd1);
    chk_val("t4_pop0_data", resp.resp_data, 32'h1111_0000);
    chk_val("t4_pop0_ready", 32'(req_ready), 32'd0);
    idle(1'b1);
    chk_val("t4_ready_back", 32'(req_ready), 32'd1);
    chk_val("t4_pop1_data", resp.resp_data, 32'h1111_0001);
    idle(1'b1);
    chk_val("t4_pop2_valid", 32'(resp_valid), 32'd1);
    chk_val("t4_pop2_data", resp.resp_data, 32'h1111_0002);
    idle(1'b1);
    chk_val("t4_no_extra", 32'(resp_valid), 32'd0);

    // Reset while reads are in flight
    drive(1'b0, 1'b1, MEM_READ, 32'h14, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, MEM_READ, 32'h18, 32'h0, 4'h0, 1'b1);
    chk_val("t5_rst_req_ready", 32'(req_ready), 32'd0);
    chk_val("t5_rst_sram_ce", 32'(sram_ce), 32'd0);
    idle(1'b1);
    chk_val("t5_resp_t2", 32'(resp_valid), 32'd0);
    idle(1'b1);
    chk_val("t5_req_ready_t3", 32'(req_ready), 32'd1);
    chk_val("t5_resp_t3", 32'(resp_valid), 32'd0);
    idle(1'b1);
    chk_val("t5_resp_t4", 32'(resp_valid), 32'd0);
    chk_val("t5_resp_b_t4", 32'(resp_valid_b), 32'd0);

    // Write responses enabled, and unknown request types
    drive(1'b0, 1'b1, MEM_WRITE, 32'h80, 32'hCAFEF00D, 4'hF, 1'b1);
    chk_val("t6_wr_sram_we", 32'(sram_we_b), 32'd1);
    idle(1'b1);
    chk_val("t6_wr_early", 32'(resp_valid_b), 32'd0);
    idle(1'b1);
    chk_val("t6_wr_valid", 32'(resp_valid_b), 32'd1);
    chk_val("t6_wr_type", 32'(resp_b.resp_type), 32'(MEM_WRITE));
    chk_val("t6_wr_data", resp_b.resp_data, 32'h0);
    chk_val("t6_silent_inst", 32'(resp_valid), 32'd0);
    idle(1'b1);
    chk_val("t6_wr_done", 32'(resp_valid_b), 32'd0);
    drive(1'b0, 1'b1, MEM_RSVD, 32'h44, 32'h55AA55AA, 4'hF, 1'b1);
    chk_val("t6_unk_ready", 32'(req_ready_b), 32'd1);
    chk_val("t6_unk_ce", 32'(sram_ce_b), 32'd0);
    chk_val("t6_unk_ce_a", 32'(sram_ce), 32'd0);
    chk_val("t6_unk_we", 32'(sram_we_b), 32'd0);
    idle(1'b1);
    idle(1'b1);
    chk_val("t6_unk_no_resp_b", 32'(resp_valid_b), 32'd0);
    chk_val("t6_unk_no_resp_a", 32'(resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
